// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and next-PC controller for the 16-bit word-addressed fetch stage.
// Selects sequential, branch-relative, absolute-jump or hold each cycle; sequences start-up, flush bubbles and halt.
module pc_fetch_ctrl #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VEC    = 16'h0000,
  parameter int                    FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jumpAddr,
  input  logic                  branchTaken,
  input  logic [ADDR_WIDTH-1:0] branchOffset,
  input  logic [ADDR_WIDTH-1:0] incrAddr,
  output logic [ADDR_WIDTH-1:0] pcAddr,
  output logic                  fetchValid,
  output logic                  flush,
  output logic [1:0]            ctrlState
);

  typedef enum logic [1:0] {
    ST_START  = 2'b00,
    ST_RUN    = 2'b01,
    ST_FLUSH  = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  // Counter is loaded with bubbles-remaining-minus-one so that zero marks the final bubble.
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t                  state_r, state_next_s;
  logic [ADDR_WIDTH-1:0]   pc_r, pc_next_s;
  logic                    valid_r, valid_next_s;
  logic                    flush_r, flush_next_s;
  logic [1:0]              cnt_r, cnt_next_s;

  // State, PC and registered output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_START;
      pc_r    <= RESET_VEC;
      valid_r <= 1'b0;
      flush_r <= 1'b0;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      valid_r <= valid_next_s;
      flush_r <= flush_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state and next-PC selection; RUN requests are resolved in priority order.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    valid_next_s = valid_r;
    flush_next_s = flush_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_START: begin
        state_next_s = ST_RUN;
        valid_next_s = 1'b1;
        flush_next_s = 1'b0;
      end
      ST_RUN: begin
        if (halt) begin
          state_next_s = ST_HALTED;
          valid_next_s = 1'b0;
          flush_next_s = 1'b0;
        end else if (jump || branchTaken) begin
          // Redirects win over stall; the branch sum wraps modulo 2^16.
          pc_next_s    = jump ? jumpAddr : (incrAddr + branchOffset);
          state_next_s = ST_FLUSH;
          valid_next_s = 1'b0;
          flush_next_s = 1'b1;
          cnt_next_s   = FLUSH_INIT;
        end else if (stall) begin
          pc_next_s    = pc_r;
        end else begin
          pc_next_s    = incrAddr;
          valid_next_s = 1'b1;
          flush_next_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (halt) begin
          state_next_s = ST_HALTED;
          valid_next_s = 1'b0;
          flush_next_s = 1'b0;
        end else if (cnt_r == 2'd0) begin
          state_next_s = ST_RUN;
          valid_next_s = 1'b1;
          flush_next_s = 1'b0;
        end else begin
          cnt_next_s   = cnt_r - 2'd1;
        end
      end
      ST_HALTED: begin
        valid_next_s = 1'b0;
        flush_next_s = 1'b0;
      end
      default: begin
        state_next_s = ST_START;
        pc_next_s    = RESET_VEC;
        valid_next_s = 1'b0;
        flush_next_s = 1'b0;
        cnt_next_s   = 2'd0;
      end
    endcase
  end

  assign pcAddr     = pc_r;
  assign fetchValid = valid_r;
  assign flush      = flush_r;
  assign ctrlState  = state_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: two instances (1- and 3-cycle bubbles) share stimulus and are compared
// every cycle against an abstract reference model, plus hand-computed directed expectations.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, halt, jump, branchTaken;
  logic [15:0] jumpAddr, branchOffset, skew;
  logic [15:0] incr1, incr3, pc1, pc3;
  logic        fv1, fv3, fl1, fl3;
  logic [1:0]  st1, st3;

  int total = 0;
  int bad   = 0;
  bit en    = 1'b0;

  always #5 clk = ~clk;

  assign incr1 = pc1 + 16'd1 + skew;
  assign incr3 = pc3 + 16'd1 + skew;

  pc_fetch_ctrl #(.ADDR_WIDTH(16), .RESET_VEC(16'h0000), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .jump(jump), .jumpAddr(jumpAddr),
    .branchTaken(branchTaken), .branchOffset(branchOffset), .incrAddr(incr1),
    .pcAddr(pc1), .fetchValid(fv1), .flush(fl1), .ctrlState(st1));

  pc_fetch_ctrl #(.ADDR_WIDTH(16), .RESET_VEC(16'h0000), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt), .jump(jump), .jumpAddr(jumpAddr),
    .branchTaken(branchTaken), .branchOffset(branchOffset), .incrAddr(incr3),
    .pcAddr(pc3), .fetchValid(fv3), .flush(fl3), .ctrlState(st3));

  // Abstract model: bubbles = flush cycles still to be shown.
  typedef struct {
    bit          started;
    bit          halted;
    int          bubbles;
    logic [15:0] pc;
  } mdl_t;

  mdl_t m1, m3;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.started = 1'b0;
    m.halted  = 1'b0;
    m.bubbles = 0;
    m.pc      = 16'h0000;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int fc);
    mdl_t n = m;
    logic [15:0] seq = m.pc + 16'd1 + skew;
    if (!m.started) n.started = 1'b1;
    else if (m.halted) n = m;
    else if (m.bubbles > 0) begin
      if (halt) begin n.halted = 1'b1; n.bubbles = 0; end
      else n.bubbles = m.bubbles - 1;
    end else if (halt) n.halted = 1'b1;
    else if (jump) begin n.pc = jumpAddr; n.bubbles = fc; end
    else if (branchTaken) begin n.pc = seq + branchOffset; n.bubbles = fc; end
    else if (!stall) n.pc = seq;
    return n;
  endfunction

  function automatic logic exp_fv(mdl_t m);
    return m.started && !m.halted && (m.bubbles == 0);
  endfunction

  function automatic logic exp_fl(mdl_t m);
    return !m.halted && (m.bubbles > 0);
  endfunction

  function automatic logic [1:0] exp_st(mdl_t m);
    if (!m.started) return 2'b00;
    if (m.halted) return 2'b11;
    if (m.bubbles > 0) return 2'b10;
    return 2'b01;
  endfunction

  // Model advances on the same edges as the DUTs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= mdl_reset();
      m3 <= mdl_reset();
    end else begin
      m1 <= mdl_step(m1, 1);
      m3 <= mdl_step(m3, 3);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (en) begin
      check("m_pc1", {16'd0, pc1}, {16'd0, m1.pc});
      check("m_fv1", {31'd0, fv1}, {31'd0, exp_fv(m1)});
      check("m_fl1", {31'd0, fl1}, {31'd0, exp_fl(m1)});
      check("m_st1", {30'd0, st1}, {30'd0, exp_st(m1)});
      check("m_pc3", {16'd0, pc3}, {16'd0, m3.pc});
      check("m_fv3", {31'd0, fv3}, {31'd0, exp_fv(m3)});
      check("m_fl3", {31'd0, fl3}, {31'd0, exp_fl(m3)});
      check("m_st3", {30'd0, st3}, {30'd0, exp_st(m3)});
    end
  end

  task automatic idle();
    stall = 1'b0; halt = 1'b0; jump = 1'b0; branchTaken = 1'b0;
    jumpAddr = 16'h0000; branchOffset = 16'h0000; skew = 16'h0000;
  endtask

  // Synchronous-looking reset; returns at a negedge with both DUTs in RUN at pc=0.
  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_pc", {16'd0, pc1}, 32'h0000_0000);
    check("rst_fv", {31'd0, fv1}, 32'd0);
    check("rst_st", {30'd0, st3}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic adv(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2 en = 1'b1;

    // 1. reset and sequential fetch
    @(negedge clk);
    check("t1_start_pc", {16'd0, pc1}, 32'h0);
    check("t1_start_fv", {31'd0, fv1}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_seq_pc", {16'd0, pc1}, i);
      check("t1_seq_fv", {31'd0, fv1}, 32'd1);
      check("t1_seq_fl", {31'd0, fl1}, 32'd0);
    end

    // 2. stall, then jump overriding stall (1-cycle bubble)
    do_reset();
    adv(5);
    check("t2_at5", {16'd0, pc1}, 32'h5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_hold", {16'd0, pc1}, 32'h5);
    end
    jump = 1'b1; jumpAddr = 16'h0100;
    @(negedge clk);
    idle();
    check("t2_jpc", {16'd0, pc1}, 32'h0100);
    check("t2_jfl", {31'd0, fl1}, 32'd1);
    check("t2_jfv", {31'd0, fv1}, 32'd0);
    @(negedge clk);
    check("t2_tgt_fv", {31'd0, fv1}, 32'd1);
    check("t2_tgt_fl", {31'd0, fl1}, 32'd0);
    @(negedge clk);
    check("t2_next", {16'd0, pc1}, 32'h0101);
    check("t2_next_fv", {31'd0, fv1}, 32'd1);

    // 3. negative branch and wrap-around
    do_reset();
    adv(2);
    branchTaken = 1'b1; branchOffset = 16'hFFFA;
    @(negedge clk);
    idle();
    check("t3_br", {16'd0, pc1}, 32'hFFFD);
    adv(3);
    check("t3_ffff", {16'd0, pc1}, 32'hFFFF);
    @(negedge clk);
    check("t3_wrap", {16'd0, pc1}, 32'h0000);

    // 4. 3-cycle bubble with masked requests
    do_reset();
    jump = 1'b1; jumpAddr = 16'h0040;
    @(negedge clk);
    branchTaken = 1'b1; branchOffset = 16'h0010; jumpAddr = 16'h0200;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("t4_fl", {31'd0, fl3}, 32'd1);
      check("t4_pc", {16'd0, pc3}, 32'h0040);
      check("t4_fv", {31'd0, fv3}, 32'd0);
    end
    idle();
    @(negedge clk);
    check("t4_end_fl", {31'd0, fl3}, 32'd0);
    check("t4_end_fv", {31'd0, fv3}, 32'd1);
    check("t4_end_pc", {16'd0, pc3}, 32'h0040);
    @(negedge clk);
    check("t4_next", {16'd0, pc3}, 32'h0041);

    // 5. halt precedence, absorbing halt, async reset
    do_reset();
    adv(9);
    halt = 1'b1; jump = 1'b1; jumpAddr = 16'h0077;
    @(negedge clk);
    idle();
    check("t5_st", {30'd0, st1}, 32'h3);
    check("t5_pc", {16'd0, pc1}, 32'h9);
    check("t5_fv", {31'd0, fv1}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      stall = 1'($urandom); jump = 1'($urandom); branchTaken = 1'($urandom);
      jumpAddr = 16'($urandom); branchOffset = 16'($urandom);
      @(negedge clk);
      check("t5_hold_pc", {16'd0, pc3}, 32'h9);
      check("t5_hold_st", {30'd0, st3}, 32'h3);
    end
    idle();
    #2 rst = 1'b1;
    #1;
    check("t5_arst_pc", {16'd0, pc1}, 32'h0);
    check("t5_arst_st", {30'd0, st1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 6. reset in the middle of a bubble
    @(negedge clk);
    jump = 1'b1; jumpAddr = 16'h0123;
    @(negedge clk);
    idle();
    check("t6_inflush", {31'd0, fl3}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_arst_fl", {31'd0, fl3}, 32'd0);
    check("t6_arst_fv", {31'd0, fv3}, 32'd0);
    check("t6_arst_pc", {16'd0, pc3}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_run_st", {30'd0, st3}, 32'h1);
    check("t6_run_fv", {31'd0, fv3}, 32'd1);
    @(negedge clk);
    check("t6_run_pc", {16'd0, pc3}, 32'h1);

    // Randomized traffic, checked by the per-cycle model comparison.
    for (int i = 0; i < 3000; i++) begin
      rst          = (m1.halted && $urandom_range(0, 7) == 0) || ($urandom_range(0, 299) == 0);
      halt         = ($urandom_range(0, 199) == 0);
      jump         = ($urandom_range(0, 9) == 0);
      branchTaken  = ($urandom_range(0, 7) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      jumpAddr     = 16'($urandom);
      branchOffset = 16'($urandom);
      skew         = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'h0000;
      @(negedge clk);
    end
    rst = 1'b0;
    idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter register and next-PC controller for the 16-bit word-addressed fetch stage.
- Drives the current fetch address to instruction memory and to the PC incrementer, then takes the incremented address (PC+1) back as `incrAddr`.
- Each cycle it selects the next PC from: sequential, branch-relative, absolute jump or hold.
- Sequences start-up, redirect flush bubbles and halt with a small state machine.

Parameters:
- ADDR_WIDTH, 16: width of all address ports. Fixed 16 in this design; parameterised for reuse.
- RESET_VEC, 16'h0000: PC value loaded on reset.
- FLUSH_CYCLES, 1: bubble cycles after a taken branch or jump. Legal range 1..4.

Ports:
- clk  input  1: single clock, rising edge.
- rst  input  1: asynchronous, active-high reset.
- stall  input  1: hold PC (decode/hazard stall).
- halt  input  1: stop fetch permanently until reset.
- jump  input  1: absolute redirect request.
- jumpAddr  input  16: jump target.
- branchTaken  input  1: relative redirect request.
- branchOffset  input  16: signed word offset, relative to PC+1.
- incrAddr  input  16: PC+1 from the incrementer stage (combinational from pcAddr).
- pcAddr  output  16: current fetch address, registered.
- fetchValid  output  1: pcAddr is a valid fetch this cycle, registered.
- flush  output  1: squash the instruction in IF/ID, registered.
- ctrlState  output  2: state encoding, for debug and verification.

Behaviour:
- Reset (async, asserted at any time, including mid-flush or mid-halt):
  - pcAddr=RESET_VEC, fetchValid=0, flush=0, state=START (ctrlState=2'b00), flush counter=0.
- States: START=00, RUN=01, FLUSH=10, HALTED=11.
- START:
  - First clk edge after rst deasserts: state->RUN, fetchValid->1, pcAddr holds RESET_VEC.
  - All request inputs are ignored in START.
- RUN, evaluated each edge in strict priority order:
  1. halt: state->HALTED, fetchValid->0, pcAddr holds.
  2. jump: pcAddr<=jumpAddr, state->FLUSH, flush->1, fetchValid->0, counter<=FLUSH_CYCLES-1.
  3. branchTaken: pcAddr<=incrAddr+branchOffset, modulo 2^16. Then the same FLUSH entry as jump.
  4. stall: pcAddr, fetchValid and flush all hold.
  5. Otherwise: pcAddr<=incrAddr, fetchValid=1.
- Jump/branch override stall: a redirect is taken even if stall is asserted in the same cycle.
- Wrap-around: incrAddr=16'h0000 when pcAddr=16'hFFFF is accepted as-is. Branch sum truncates to 16 bits; no overflow flag.
- FLUSH:
  - flush=1 and fetchValid=0 for exactly FLUSH_CYCLES cycles; pcAddr holds the target.
  - If counter==0 at an edge: state->RUN, flush->0, fetchValid->1. Otherwise decrement the counter.
  - jump and branchTaken are ignored (they come from squashed instructions). stall is ignored and does not extend the bubble.
  - halt in FLUSH: state->HALTED, flush->0, fetchValid->0.
- HALTED: absorbing until rst. pcAddr holds, fetchValid=0, flush=0, all inputs ignored.
- Latency: a redirect requested in RUN at edge N gives pcAddr=target after edge N. The target is first fetched with fetchValid=1 after edge N+FLUSH_CYCLES.
- incrAddr is not checked against pcAddr+1. Correctness of the incrementer is the upstream stage's responsibility.

Test Plan:
1. Reset and sequential fetch:
   - Stimulus: assert rst, release, run 4 clocks.
   - Required: pcAddr=0, fetchValid=0 in START. Then pcAddr=0,1,2,3 with fetchValid=1 and flush=0.
2. Stall, then jump overriding stall:
   - Stimulus: at pcAddr=5, stall for 3 clocks; then assert jump=1 with jumpAddr=16'h0100 while stall=1.
   - Required: pcAddr holds 5 for 3 cycles. Then pcAddr=16'h0100, flush=1 and fetchValid=0 for 1 cycle, then pcAddr=16'h0101, fetchValid=1.
3. Negative branch and wrap-around:
   - Stimulus: at pcAddr=16'h0002 (incrAddr=3), branchTaken with branchOffset=16'hFFFA.
   - Required: pcAddr=16'hFFFD after the edge.
   - Stimulus: at pcAddr=16'hFFFF, no branch.
   - Required: next pcAddr=16'h0000.
4. Flush length and masked requests:
   - Stimulus: FLUSH_CYCLES=3; jump to 16'h0040; assert branchTaken and jump during the bubble.
   - Required: flush=1 for exactly 3 cycles, pcAddr stays 16'h0040, the bubble-time requests are ignored. Then fetchValid=1 and pcAddr=16'h0041.
5. Halt precedence and reset recovery:
   - Stimulus: assert halt and jump together in RUN at pcAddr=9.
   - Required: HALTED, pcAddr=9, fetchValid=0.
   - Stimulus: then toggle stall, jump and branchTaken.
   - Required: no change.
   - Stimulus: assert rst asynchronously, between clock edges.
   - Required: pcAddr=RESET_VEC and ctrlState=00 immediately, before the next edge.
6. Reset mid-flush:
   - Stimulus: assert rst during the FLUSH state.
   - Required: flush=0, fetchValid=0 and pcAddr=RESET_VEC immediately. Normal start-up follows.
